// File: rtl/reg_file_seq_pkg.sv
// rtl/reg_file_seq_pkg.sv - shared constants and types for the register-file sequencer
// Purpose: datapath/address widths, opcode encoding and FSM state encoding.
// Optional feature macro used by importers: REG_SEQ_FLAGS_EN.
package reg_file_seq_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;

    typedef enum logic [2:0] {
        OP_MOV = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_LDI = 3'd6,
        OP_CMP = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/reg_file_seq_alu.sv
// rtl/reg_file_seq_alu.sv - combinational ALU for the register-file sequencer
// Purpose: computes the instruction result at DATA_W+1 bits and truncates it.
// Ports:
//   opcode  in  operation select
//   a, b    in  captured source operands
//   imm     in  immediate operand (LDI)
//   result  out DATA_W-bit wrapped result
//   carry   out carry-out for ADD, borrow for SUB/CMP, 0 otherwise
module reg_file_seq_alu
    import reg_file_seq_pkg::*;
(
    input  opcode_t           opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide = '0;
        case (opcode)
            OP_MOV:         wide = {1'b0, a};
            OP_ADD:         wide = {1'b0, a} + {1'b0, b};
            // The extra top bit of a zero-extended subtraction is the borrow.
            OP_SUB, OP_CMP: wide = {1'b0, a} - {1'b0, b};
            OP_AND:         wide = {1'b0, a & b};
            OP_OR:          wide = {1'b0, a | b};
            OP_XOR:         wide = {1'b0, a ^ b};
            OP_LDI:         wide = {1'b0, imm};
            default:        wide = '0;
        endcase
        result = wide[DATA_W-1:0];
        carry  = ((opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_CMP))
                 ? wide[DATA_W] : 1'b0;
    end

endmodule

// File: rtl/reg_file_sequencer.sv
// rtl/reg_file_sequencer.sv - single-master micro-sequencer for a 64 x 16 register file
// Purpose: accepts one instruction per handshake, reads operands through the file's
// async ports, executes, and writes back through the sync write port (port A reused
// as write address). Optional status flags under macro REG_SEQ_FLAGS_EN.
// Ports:
//   Clock, Reset                     clock, synchronous active-high reset
//   InstrValid/InstrReady            instruction handshake
//   Opcode, Dest, SrcA, SrcB, Immediate  instruction fields (sampled at accept)
//   RegAddressA/B, RegWriteEnable, RegWriteData  to register file
//   RegReadDataA/B                   from register file
//   Done                             one-cycle retire pulse
//   Zero, Carry                      status flags (REG_SEQ_FLAGS_EN only)
module reg_file_sequencer
    import reg_file_seq_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              InstrValid,
    output logic              InstrReady,
    input  logic [2:0]        Opcode,
    input  logic [ADDR_W-1:0] Dest,
    input  logic [ADDR_W-1:0] SrcA,
    input  logic [ADDR_W-1:0] SrcB,
    input  logic [DATA_W-1:0] Immediate,
    output logic [ADDR_W-1:0] RegAddressA,
    output logic [ADDR_W-1:0] RegAddressB,
    output logic              RegWriteEnable,
    output logic [DATA_W-1:0] RegWriteData,
    input  logic [DATA_W-1:0] RegReadDataA,
    input  logic [DATA_W-1:0] RegReadDataB,
    output logic              Done
`ifdef REG_SEQ_FLAGS_EN
    ,
    output logic              Zero,
    output logic              Carry
`endif
);

    seq_state_t        state_q,  state_d;
    opcode_t           opcode_q, opcode_d;
    logic [ADDR_W-1:0] dest_q,   dest_d;
    logic [ADDR_W-1:0] src_a_q,  src_a_d;
    logic [ADDR_W-1:0] src_b_q,  src_b_d;
    logic [DATA_W-1:0] imm_q,    imm_d;
    logic [DATA_W-1:0] op_a_q,   op_a_d;
    logic [DATA_W-1:0] op_b_q,   op_b_d;
    logic [DATA_W-1:0] result_q, result_d;
`ifdef REG_SEQ_FLAGS_EN
    logic              zero_q,   zero_d;
    logic              carry_q,  carry_d;
`endif

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    reg_file_seq_alu u_alu (
        .opcode (opcode_q),
        .a      (op_a_q),
        .b      (op_b_q),
        .imm    (imm_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        dest_d         = dest_q;
        src_a_d        = src_a_q;
        src_b_d        = src_b_q;
        imm_d          = imm_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        result_d       = result_q;
`ifdef REG_SEQ_FLAGS_EN
        zero_d         = zero_q;
        carry_d        = carry_q;
`endif
        InstrReady     = (state_q == ST_IDLE) && !Reset;
        RegAddressA    = '0;
        RegAddressB    = '0;
        RegWriteEnable = 1'b0;
        RegWriteData   = '0;
        Done           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (InstrValid && InstrReady) begin
                    opcode_d = opcode_t'(Opcode);
                    dest_d   = Dest;
                    src_a_d  = SrcA;
                    src_b_d  = SrcB;
                    imm_d    = Immediate;
                    // LDI needs no register operands, so it skips the read cycle.
                    state_d  = (opcode_t'(Opcode) == OP_LDI) ? ST_EXEC : ST_READ;
                end
            end
            ST_READ: begin
                RegAddressA = src_a_q;
                RegAddressB = src_b_q;
                op_a_d      = RegReadDataA;
                op_b_d      = RegReadDataB;
                state_d     = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_result;
`ifdef REG_SEQ_FLAGS_EN
                if ((opcode_q != OP_MOV) && (opcode_q != OP_LDI)) begin
                    zero_d  = (alu_result == '0);
                    carry_d = alu_carry;
                end
`endif
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                RegAddressA    = dest_q;
                RegWriteData   = result_q;
                // Reset landing on the write cycle must not commit or retire.
                RegWriteEnable = (opcode_q != OP_CMP) && !Reset;
                Done           = !Reset;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            opcode_q <= OP_MOV;
            dest_q   <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            imm_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
`ifdef REG_SEQ_FLAGS_EN
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            dest_q   <= dest_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            imm_q    <= imm_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
`ifdef REG_SEQ_FLAGS_EN
            zero_q   <= zero_d;
            carry_q  <= carry_d;
`endif
        end
    end

`ifdef REG_SEQ_FLAGS_EN
    assign Zero  = zero_q;
    assign Carry = carry_q;
`endif

endmodule

// File: tb/tb_reg_file_sequencer.sv
// tb/tb_reg_file_sequencer.sv - directed self-checking bench for reg_file_sequencer
module tb_reg_file_sequencer;
    import reg_file_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        rdy;
    logic [2:0]  opcode;
    logic [5:0]  dest, src_a, src_b;
    logic [15:0] imm;
    logic [5:0]  addr_a, addr_b;
    logic        we;
    logic [15:0] wdata, rd_a, rd_b;
    logic        done;
`ifdef REG_SEQ_FLAGS_EN
    logic        zero, carry;
`endif

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    int done_count = 0;
    int cyc = 0;
    int we0, d0;
    int acc [3];

    logic [2:0] bp_op   [3] = '{3'd1, 3'd2, 3'd5};
    logic [5:0] bp_dest [3] = '{6'd20, 6'd21, 6'd22};
    logic [5:0] bp_a    [3] = '{6'd1, 6'd2, 6'd1};
    logic [5:0] bp_b    [3] = '{6'd2, 6'd1, 6'd2};

    logic [15:0] rf [64];

    always #5 clk = ~clk;

    always @(posedge clk) if (we) rf[addr_a] <= wdata;
    assign rd_a = rf[addr_a];
    assign rd_b = rf[addr_b];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we)   we_count   <= we_count + 1;
        if (done) done_count <= done_count + 1;
    end

    reg_file_sequencer dut (
        .Clock          (clk),
        .Reset          (rst),
        .InstrValid     (valid),
        .InstrReady     (rdy),
        .Opcode         (opcode),
        .Dest           (dest),
        .SrcA           (src_a),
        .SrcB           (src_b),
        .Immediate      (imm),
        .RegAddressA    (addr_a),
        .RegAddressB    (addr_b),
        .RegWriteEnable (we),
        .RegWriteData   (wdata),
        .RegReadDataA   (rd_a),
        .RegReadDataB   (rd_b),
        .Done           (done)
`ifdef REG_SEQ_FLAGS_EN
        ,
        .Zero           (zero),
        .Carry          (carry)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [5:0] d, input logic [5:0] a,
                         input logic [5:0] b, input logic [15:0] im);
        valid  = 1'b1;
        opcode = op;
        dest   = d;
        src_a  = a;
        src_b  = b;
        imm    = im;
    endtask

    // Fields scrambled after accept: the DUT must use its latched copy.
    task automatic release_bus();
        valid  = 1'b0;
        opcode = 3'($urandom);
        dest   = 6'($urandom);
        src_a  = 6'($urandom);
        src_b  = 6'($urandom);
        imm    = 16'($urandom);
    endtask

    task automatic run(input logic [2:0] op, input logic [5:0] d, input logic [5:0] a,
                       input logic [5:0] b, input logic [15:0] im);
        int n;
        n = 0;
        while (!rdy && n < 20) begin @(negedge clk); n++; end
        chk("run_ready", rdy, 1);
        drive(op, d, a, b, im);
        @(negedge clk);
        release_bus();
        n = 0;
        while (!done && n < 8) begin @(negedge clk); n++; end
        chk("run_done", done, 1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        release_bus();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", rdy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", we, 0);
        chk("rst_addr_a", addr_a, 0);
        chk("rst_addr_b", addr_b, 0);
        chk("rst_wdata", wdata, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", rdy, 1);

        // LDI r5 = 0x1234, exact timing
        we0 = we_count; d0 = done_count;
        drive(OP_LDI, 6'd5, 6'd0, 6'd0, 16'h1234);
        @(negedge clk);
        release_bus();
        chk("ldi_exec_ready", rdy, 0);
        chk("ldi_exec_done", done, 0);
        chk("ldi_exec_we", we, 0);
        @(negedge clk);
        chk("ldi_wr_we", we, 1);
        chk("ldi_wr_addr", addr_a, 5);
        chk("ldi_wr_data", wdata, 16'h1234);
        chk("ldi_wr_done", done, 1);
        @(negedge clk);
        chk("ldi_idle_we", we, 0);
        chk("ldi_idle_done", done, 0);
        chk("ldi_idle_ready", rdy, 1);
        chk("ldi_r5", rf[5], 16'h1234);
        chk("ldi_we_pulses", we_count - we0, 1);
        chk("ldi_done_pulses", done_count - d0, 1);

        // ADD wrap: r1=FFFF, r2=0001 -> r3=0
        run(OP_LDI, 6'd1, 6'd0, 6'd0, 16'hFFFF);
        run(OP_LDI, 6'd2, 6'd0, 6'd0, 16'h0001);
        drive(OP_ADD, 6'd3, 6'd1, 6'd2, 16'h0);
        @(negedge clk);
        release_bus();
        chk("add_read_addr_a", addr_a, 1);
        chk("add_read_addr_b", addr_b, 2);
        chk("add_read_done", done, 0);
        @(negedge clk);
        chk("add_exec_addr_a", addr_a, 0);
        chk("add_exec_addr_b", addr_b, 0);
        chk("add_exec_we", we, 0);
        @(negedge clk);
        chk("add_wr_done", done, 1);
        chk("add_wr_we", we, 1);
        chk("add_wr_addr_a", addr_a, 3);
        chk("add_wr_addr_b", addr_b, 0);
        chk("add_wr_data", wdata, 16'h0000);
`ifdef REG_SEQ_FLAGS_EN
        chk("add_carry", carry, 1);
        chk("add_zero", zero, 1);
`endif
        @(negedge clk);
        chk("add_r3", rf[3], 16'h0000);
        chk("add_ready", rdy, 1);

        // SUB borrow: r1=3, r2=5 -> r4=FFFE
        run(OP_LDI, 6'd1, 6'd0, 6'd0, 16'd3);
        run(OP_LDI, 6'd2, 6'd0, 6'd0, 16'd5);
        run(OP_SUB, 6'd4, 6'd1, 6'd2, 16'h0);
        chk("sub_r4", rf[4], 16'hFFFE);
`ifdef REG_SEQ_FLAGS_EN
        chk("sub_carry", carry, 1);
        chk("sub_zero", zero, 0);
`endif

        // CMP r1,r1 with Dest=1: no write, Done still pulses
        we0 = we_count; d0 = done_count;
        run(OP_CMP, 6'd1, 6'd1, 6'd1, 16'h0);
        chk("cmp_no_write", we_count - we0, 0);
        chk("cmp_done", done_count - d0, 1);
        chk("cmp_r1_kept", rf[1], 16'd3);
`ifdef REG_SEQ_FLAGS_EN
        chk("cmp_zero", zero, 1);
        chk("cmp_carry", carry, 0);
`endif

        // Logic ops and MOV on r1=3, r2=5
        run(OP_AND, 6'd10, 6'd1, 6'd2, 16'h0);
        chk("and_r10", rf[10], 16'h0001);
        run(OP_OR, 6'd11, 6'd1, 6'd2, 16'h0);
        chk("or_r11", rf[11], 16'h0007);
        run(OP_XOR, 6'd12, 6'd1, 6'd2, 16'h0);
        chk("xor_r12", rf[12], 16'h0006);
        run(OP_MOV, 6'd13, 6'd2, 6'd1, 16'h0);
        chk("mov_r13", rf[13], 16'h0005);

        // Aliased operands
        run(OP_LDI, 6'd7, 6'd0, 6'd0, 16'h0101);
        run(OP_ADD, 6'd7, 6'd7, 6'd7, 16'h0);
        chk("alias_r7", rf[7], 16'h0202);

        // Back-pressure: InstrValid held across three instructions
        we0 = we_count; d0 = done_count;
        for (int k = 0; k < 3; k++) begin
            int n;
            drive(bp_op[k], bp_dest[k], bp_a[k], bp_b[k], 16'h0);
            n = 0;
            while (!rdy && n < 12) begin @(negedge clk); n++; end
            chk("bp_ready", rdy, 1);
            acc[k] = cyc;
            @(negedge clk);
        end
        release_bus();
        begin
            int n;
            n = 0;
            while (!done && n < 8) begin @(negedge clk); n++; end
            chk("bp_last_done", done, 1);
            @(negedge clk);
        end
        chk("bp_gap_0_1", acc[1] - acc[0], 4);
        chk("bp_gap_1_2", acc[2] - acc[1], 4);
        chk("bp_r20", rf[20], 16'd8);
        chk("bp_r21", rf[21], 16'd2);
        chk("bp_r22", rf[22], 16'd6);
        chk("bp_writes", we_count - we0, 3);
        chk("bp_dones", done_count - d0, 3);

        // Reset during WRITE of ADD Dest=9
        run(OP_LDI, 6'd9, 6'd0, 6'd0, 16'h5555);
        we0 = we_count; d0 = done_count;
        drive(OP_ADD, 6'd9, 6'd1, 6'd2, 16'h0);
        @(negedge clk);
        release_bus();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_we", we, 0);
        chk("rstw_done", done, 0);
        @(negedge clk);
        chk("rstw_ready_in_rst", rdy, 0);
        chk("rstw_r9_in_rst", rf[9], 16'h5555);
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_ready_after", rdy, 1);
        chk("rstw_done_after", done, 0);
        chk("rstw_r9", rf[9], 16'h5555);
        chk("rstw_no_write", we_count - we0, 0);
        chk("rstw_no_done", done_count - d0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sequencer.md
# reg_file_sequencer

Micro-sequencer that sits directly upstream of the 64 x 16-bit register file and is its only master. It accepts one register-to-register instruction at a time over a valid/ready handshake. It reads operands through the file's two asynchronous read ports, computes the result, and writes it back through the file's synchronous write port, reusing port A as the write address.

## Interface
- `DATA_W`, 16: datapath width; must match the register file.
- `ADDR_W`, 6: register address width (64 registers).
- `Clock`  in  1: rising-edge clock, shared with the register file.
- `Reset`  in  1: synchronous, active-high.
- `InstrValid`  in  1: instruction fields are valid.
- `InstrReady`  out  1: sequencer can accept an instruction.
- `Opcode`  in  3: operation (see Operation).
- `Dest`, `SrcA`, `SrcB`  in  ADDR_W each: destination and source register numbers.
- `Immediate`  in  DATA_W: operand for LDI.
- `RegAddressA`, `RegAddressB`  out  ADDR_W: to the register file `AddressA`/`AddressB`.
- `RegWriteEnable`  out  1: to the register file `WriteEnable`.
- `RegWriteData`  out  DATA_W: to the register file `WriteData`.
- `RegReadDataA`, `RegReadDataB`  in  DATA_W: from the register file `ReadDataA`/`ReadDataB`.
- `Done`  out  1: one-cycle pulse when an instruction retires.
- `Zero`, `Carry`  out  1 each: status flags (only with `REG_SEQ_FLAGS_EN`).

## Operation
- **Opcodes:**
  - 0 MOV: A
  - 1 ADD: A+B
  - 2 SUB: A−B
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 LDI: Immediate
  - 7 CMP: A−B, no write
- **FSM states:** IDLE, READ, EXEC, WRITE.
  - IDLE: `InstrReady`=1. On `InstrValid`, latch all fields. Go to READ, or to EXEC for LDI.
  - READ: `RegAddressA`=SrcA, `RegAddressB`=SrcB. Capture `RegReadDataA`/`RegReadDataB` into operand registers at the closing edge. Go to EXEC.
  - EXEC: register the ALU result (and flags). Go to WRITE.
  - WRITE: `RegAddressA`=Dest, `RegWriteData`=result, `RegWriteEnable`=1 (0 for CMP). `Done`=1. Go to IDLE.
- **Address outputs:** `RegAddressA`/`RegAddressB` are 0 in IDLE and EXEC. `RegAddressB` is 0 in WRITE.
- **Arithmetic:** computed at DATA_W+1 bits; the result is truncated to DATA_W, so it wraps (0xFFFF+1 → 0x0000).
  - Carry = bit DATA_W for ADD.
  - For SUB/CMP, Carry = borrow (A<B unsigned).
- **Register aliasing:** Dest may equal SrcA/SrcB; the operands are already captured, so the result is well defined.
- **Reset values:** state IDLE, operands/result 0, all outputs 0. `InstrReady`=0 while `Reset` is high.
- **Reset mid-operation:** aborts the instruction immediately. `RegWriteEnable` is gated by `!Reset`, so a WRITE cycle coinciding with Reset does not commit. `Done` is not pulsed.
- **Handshake:** `InstrValid` held while not ready is ignored. Fields need only be stable in the accept cycle.

## Timing
- **Accept:** the edge where `InstrValid`&&`InstrReady`.
- **Latency:** the write commits at the 3rd edge after accept for normal ops, and the 2nd edge for LDI. `Done` is high during the cycle before that edge.
- **Throughput:** one instruction per 4 cycles (3 cycles for LDI). `InstrReady` reasserts in the cycle after WRITE.
- **Timing path:** the read path (address out → async file read → operand register) is a single-cycle combinational path in READ.

## Configuration
- **`REG_SEQ_FLAGS_EN` defined:**
  - `Zero`/`Carry` ports exist.
  - Flags are registered in EXEC for opcodes 1–5 and 7 and hold otherwise.
  - Zero = (result==0).
  - Flags reset to 0.
- **Undefined:**
  - Ports and flag registers are absent.
  - CMP executes as a NOP: no write, `Done` still pulses.

## Structure
- **Package `reg_file_seq_pkg`:**
  - `DATA_W`, `ADDR_W` constants.
  - `opcode_t` enum (MOV..CMP).
  - `seq_state_t` enum (IDLE, READ, EXEC, WRITE).
- **Sub-module `reg_file_seq_alu`:** purely combinational. Inputs: opcode, A, B, immediate. Outputs: DATA_W result, carry.
- **Top:** the FSM and pipeline registers. The bench instantiates the top plus the register file.

## Test plan
- **LDI:** Reset, then LDI Dest=5 Imm=0x1234 → `RegWriteEnable` high for exactly one cycle with `RegAddressA`=5. Register 5 reads 0x1234. `Done` pulses once.
- **ADD wrap:** r1=0xFFFF, r2=0x0001; ADD Dest=3 → r3=0x0000, Carry=1, Zero=1. `Done` is high 3 cycles after accept.
- **SUB borrow and CMP:** r1=3, r2=5; SUB Dest=4 → r4=0xFFFE, Carry=1. CMP r1,r1 → no write, Zero=1.
- **Aliased operands:** ADD Dest=7 SrcA=7 SrcB=7 with r7=0x0101 → r7=0x0202.
- **Back-pressure:** `InstrValid` held continuously with 3 instructions → each is accepted only when `InstrReady`=1, 4 cycles apart, and none is lost or duplicated.
- **Reset during WRITE:** Reset asserted during WRITE of ADD Dest=9 → r9 is unchanged, `Done`=0, and `InstrReady`=1 in the first cycle after Reset deasserts.
